// File: rtl/alu_pkg.sv
// alu_pkg: shared width and opcode encodings for the alu block
package alu_pkg;
    localparam int WIDTH = 8;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MAX = 3'd2;
    localparam logic [2:0] OP_MIN = 3'd3;
    localparam logic [2:0] OP_ASR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/opcode bus into the alu and registered result back out
//   a, b : signed operands      op : opcode
//   z    : signed result        of : signed-overflow flag
interface alu_if;
    import alu_pkg::*;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [WIDTH-1:0] z;
    logic             of;
    modport master (output a, b, op, input z, of);
    modport slave (input a, b, op, output z, of);
endinterface

// File: rtl/alu_addsub.sv
// alu_addsub: single shared adder computing a+b or a-b with signed overflow
//   a, b : operands    sub : 1 selects a-b
//   sum  : WIDTH-bit result    ovf : signed overflow
module alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);
    logic [WIDTH-1:0] bx;
    assign bx  = b ^ {WIDTH{sub}};
    assign sum = a + bx + {{(WIDTH-1){1'b0}}, sub};
    // overflow when both adder inputs agree in sign and the sum disagrees
    assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu.sv
// alu: registered signed ALU (add, sub, max, min, asr, shl) with overflow flag
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears z and of
//   bus   : alu_if slave; a, b, op sampled each edge, z/of valid one edge later
module alu
    import alu_pkg::*;
(
    input logic  clk,
    input logic  rst_n,
    alu_if.slave bus
);
    logic             sub;
    logic             ovf;
    logic             lt;
    logic             of_n;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] z_n;
    // every opcode except ADD uses the subtractor; MAX/MIN compare through it
    assign sub = bus.op != OP_ADD;
    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (bus.a),
        .b   (bus.b),
        .sub (sub),
        .sum (sum),
        .ovf (ovf)
    );
    // a < b exactly when the true sign of a-b is negative
    assign lt = sum[WIDTH-1] ^ ovf;
    always_comb begin
        z_n  = (bus.op == OP_ADD || bus.op == OP_SUB) ? sum :
               (bus.op == OP_MAX) ? (lt ? bus.b : bus.a) :
               (bus.op == OP_MIN) ? (lt ? bus.a : bus.b) :
               (bus.op == OP_ASR) ? {bus.a[WIDTH-1], bus.a[WIDTH-1:1]} :
               (bus.op == OP_SHL) ? {bus.b[WIDTH-2:0], 1'b0} : '0;
        of_n = (bus.op == OP_ADD || bus.op == OP_SUB) ? ovf :
               (bus.op == OP_SHL) ? (bus.b[WIDTH-1] ^ bus.b[WIDTH-2]) : 1'b0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.z  <= '0;
            bus.of <= 1'b0;
        end else begin
            bus.z  <= z_n;
            bus.of <= of_n;
        end
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu covering reset, each opcode and back-to-back issue
module tb_alu;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    alu_if bus ();
    alu dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    logic [8:0] sb[$];
    logic [8:0] exp;
    int n_cmp = 0;
    int n_err = 0;

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [7:0] ez, input logic eof);
        bus.a  = a;
        bus.b  = b;
        bus.op = op;
        sb.push_back({eof, ez});
    endtask

    // independent reference using integer arithmetic and range checks
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int sa = $signed(a);
        int sb2 = $signed(b);
        int r = 0;
        logic o = 1'b0;
        case (op)
            3'd0: begin r = sa + sb2; o = (r > 127) || (r < -128); end
            3'd1: begin r = sa - sb2; o = (r > 127) || (r < -128); end
            3'd2: r = (sa >= sb2) ? sa : sb2;
            3'd3: r = (sa <= sb2) ? sa : sb2;
            3'd4: r = sa >>> 1;
            3'd5: begin r = sb2 * 2; o = (r > 127) || (r < -128); end
            default: r = 0;
        endcase
        return {o, r[7:0]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rst_n = 1'b1;
            drive(8'd5, 8'd5, OP_ADD, (i == 2) ? 8'd10 : 8'd0, 1'b0);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_cmp++;
            if ({bus.of, bus.z} !== exp) begin
                n_err++;
                $display("FAIL reset[%0d]: got z=%0d of=%b, want z=%0d of=%b", i, $signed(bus.z), bus.of, $signed(exp[7:0]), exp[8]);
            end
        end
    endtask

    task automatic test_addsub();
        logic [7:0] ta[6] = '{8'h02, 8'h40, 8'hC4, 8'h07, 8'h9C, 8'h64};
        logic [7:0] tb[6] = '{8'h03, 8'h40, 8'hB5, 8'h03, 8'h32, 8'hCE};
        logic [2:0] to[6] = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB};
        logic [7:0] tz[6] = '{8'h05, 8'h80, 8'h79, 8'h04, 8'h6A, 8'h96};
        logic       tf[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(ta[i], tb[i], to[i], tz[i], tf[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_cmp++;
            if ({bus.of, bus.z} !== exp) begin
                n_err++;
                $display("FAIL addsub[%0d]: got z=%0d of=%b, want z=%0d of=%b", i, $signed(bus.z), bus.of, $signed(exp[7:0]), exp[8]);
            end
        end
    endtask

    task automatic test_maxmin();
        logic [7:0] ta[6] = '{8'h0C, 8'h0F, 8'h40, 8'h64, 8'h80, 8'h37};
        logic [7:0] tb[6] = '{8'h1C, 8'hE4, 8'h5F, 8'hFF, 8'h7F, 8'h37};
        logic [2:0] to[6] = '{OP_MAX, OP_MAX, OP_MIN, OP_MIN, OP_MIN, OP_MAX};
        logic [7:0] tz[6] = '{8'h1C, 8'h0F, 8'h40, 8'hFF, 8'h80, 8'h37};
        for (int i = 0; i < 6; i++) begin
            drive(ta[i], tb[i], to[i], tz[i], 1'b0);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_cmp++;
            if ({bus.of, bus.z} !== exp) begin
                n_err++;
                $display("FAIL maxmin[%0d]: got z=%0d of=%b, want z=%0d of=%b", i, $signed(bus.z), bus.of, $signed(exp[7:0]), exp[8]);
            end
        end
    endtask

    task automatic test_shift();
        logic [7:0] ta[6] = '{8'h0A, 8'hFB, 8'hFF, 8'h33, 8'h33, 8'h33};
        logic [7:0] tb[6] = '{8'h7F, 8'h7F, 8'h00, 8'h04, 8'hF8, 8'h40};
        logic [2:0] to[6] = '{OP_ASR, OP_ASR, OP_ASR, OP_SHL, OP_SHL, OP_SHL};
        logic [7:0] tz[6] = '{8'h05, 8'hFD, 8'hFF, 8'h08, 8'hF0, 8'h80};
        logic       tf[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(ta[i], tb[i], to[i], tz[i], tf[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_cmp++;
            if ({bus.of, bus.z} !== exp) begin
                n_err++;
                $display("FAIL shift[%0d]: got z=%0d of=%b, want z=%0d of=%b", i, $signed(bus.z), bus.of, $signed(exp[7:0]), exp[8]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [8:0] m;
        a = 8'($urandom);
        b = 8'($urandom);
        op = 3'd0;
        m = model(a, b, op);
        drive(a, b, op, m[7:0], m[8]);
        for (int i = 1; i <= 48; i++) begin
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_cmp++;
            if ({bus.of, bus.z} !== exp) begin
                n_err++;
                $display("FAIL b2b[%0d]: got z=%0d of=%b, want z=%0d of=%b", i - 1, $signed(bus.z), bus.of, $signed(exp[7:0]), exp[8]);
            end
            if (i < 48) begin
                a = (i % 11 == 0) ? 8'h80 : 8'($urandom);
                b = (i % 13 == 0) ? 8'h7F : 8'($urandom);
                op = 3'(i % 8);
                m = model(a, b, op);
                drive(a, b, op, m[7:0], m[8]);
            end
        end
    endtask

    initial begin
        bus.a  = '0;
        bus.b  = '0;
        bus.op = '0;
        @(negedge clk);
        test_reset();
        test_addsub();
        test_maxmin();
        test_shift();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
